// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: tag-tracking entries with CDB wakeup,
// lowest-index free allocation and lowest-index prepared dispatch.
module rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int RS_BIT  = 4,
  parameter int TAG_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [TAG_BIT-1:0] iss_rob,
  input  logic [TAG_BIT-1:0] iss_qj,
  input  logic [TAG_BIT-1:0] iss_qk,
  input  logic               iss_qj_pend,
  input  logic               iss_qk_pend,
  output logic [RS_BIT-1:0]  iss_entry,
  input  logic               cdb_valid,
  input  logic [TAG_BIT-1:0] cdb_tag,
  output logic               exe_valid,
  input  logic               exe_ready,
  output logic [RS_BIT-1:0]  exe_entry,
  output logic [TAG_BIT-1:0] exe_rob,
  output logic [RS_BIT:0]    count
);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_pend;
  logic [RS_SIZE-1:0] qk_pend;
  logic [TAG_BIT-1:0] qj  [RS_SIZE];
  logic [TAG_BIT-1:0] qk  [RS_SIZE];
  logic [TAG_BIT-1:0] rob [RS_SIZE];

  logic [RS_SIZE-1:0] prepared;
  logic               iss_go;
  logic               exe_go;
  logic               qj_byp;
  logic               qk_byp;

  // Selection looks only at registered state, so a wakeup or a
  // dispatch takes effect on the following cycle.
  always_comb begin
    prepared  = busy & ~qj_pend & ~qk_pend;
    iss_entry = '0;
    exe_entry = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i])    iss_entry = RS_BIT'(i);
      if (prepared[i]) exe_entry = RS_BIT'(i);
    end
    iss_ready = ~&busy;
    exe_valid = |prepared;
    exe_rob   = exe_valid ? rob[exe_entry] : '0;
  end

  assign iss_go = iss_valid & iss_ready & rdy_in & ~flush_in;
  assign exe_go = exe_valid & exe_ready & rdy_in & ~flush_in;
  assign qj_byp = cdb_valid & (iss_qj == cdb_tag);
  assign qk_byp = cdb_valid & (iss_qk == cdb_tag);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy    <= '0;
      qj_pend <= '0;
      qk_pend <= '0;
      count   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        qj[i]  <= '0;
        qk[i]  <= '0;
        rob[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy    <= '0;
        qj_pend <= '0;
        qk_pend <= '0;
        count   <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (cdb_valid && busy[i] && qj_pend[i] && qj[i] == cdb_tag)
            qj_pend[i] <= 1'b0;
          if (cdb_valid && busy[i] && qk_pend[i] && qk[i] == cdb_tag)
            qk_pend[i] <= 1'b0;
        end
        if (exe_go)
          busy[exe_entry] <= 1'b0;
        // Issue and dispatch never target the same entry.
        if (iss_go) begin
          busy[iss_entry]    <= 1'b1;
          rob[iss_entry]     <= iss_rob;
          qj[iss_entry]      <= iss_qj;
          qk[iss_entry]      <= iss_qk;
          qj_pend[iss_entry] <= iss_qj_pend & ~qj_byp;
          qk_pend[iss_entry] <= iss_qk_pend & ~qk_byp;
        end
        unique case ({iss_go, exe_go})
          2'b10:   count <= count + (RS_BIT+1)'(1);
          2'b01:   count <= count - (RS_BIT+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
